// File: rtl/sp_ram_req_sequencer.sv
// Serialises independent write/read request channels onto a single-port synchronous RAM
// and returns read data on a valid/ready response channel. Define SEQ_RR_ARB_EN for round-robin tie-breaking.
module sp_ram_req_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        RESP
    } state_t;

    state_t                  stateReg, stateNext;
    logic                    wrGrant, rdGrant;
    logic                    wrAccept, rdAccept;
    logic                    ramWeNext, ramOeNext;
    logic [ADDR_WIDTH-1:0]   ramAddrNext;
    logic [DATA_WIDTH-1:0]   ramDinNext;
    logic                    rspValidNext;
    logic [DATA_WIDTH-1:0]   rspDataNext;

`ifdef SEQ_RR_ARB_EN
    // lastWrReg=1 means the most recent accept was a write, so a tie goes to the read.
    logic lastWrReg, lastWrNext;

    assign wrGrant = !rd_valid || !lastWrReg;
    assign rdGrant = !wr_valid ||  lastWrReg;
`else
    assign wrGrant = 1'b1;
    assign rdGrant = !wr_valid;
`endif

    assign wr_ready = (stateReg == IDLE) && wrGrant;
    assign rd_ready = (stateReg == IDLE) && rdGrant;
    assign wrAccept = wr_valid && wr_ready;
    assign rdAccept = rd_valid && rd_ready;

    always_comb begin
        stateNext    = stateReg;
        ramWeNext    = 1'b0;
        ramOeNext    = 1'b0;
        ramAddrNext  = ram_addr;
        ramDinNext   = ram_din;
        rspValidNext = rsp_valid;
        rspDataNext  = rsp_data;
`ifdef SEQ_RR_ARB_EN
        lastWrNext   = lastWrReg;
`endif
        case (stateReg)
            IDLE: begin
                if (wrAccept) begin
                    stateNext   = WR;
                    ramWeNext   = 1'b1;
                    ramAddrNext = wr_addr;
                    ramDinNext  = wr_data;
`ifdef SEQ_RR_ARB_EN
                    lastWrNext  = 1'b1;
`endif
                end else if (rdAccept) begin
                    stateNext   = RD_ISSUE;
                    ramOeNext   = 1'b1;
                    ramAddrNext = rd_addr;
`ifdef SEQ_RR_ARB_EN
                    lastWrNext  = 1'b0;
`endif
                end
            end
            WR:       stateNext = IDLE;
            RD_ISSUE: stateNext = RD_CAP;
            // RAM registered its output on the previous edge; capture it now.
            RD_CAP: begin
                stateNext    = RESP;
                rspValidNext = 1'b1;
                rspDataNext  = ram_dout;
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext    = IDLE;
                    rspValidNext = 1'b0;
                end
            end
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef SEQ_RR_ARB_EN
            lastWrReg <= 1'b0;
`endif
        end else begin
            stateReg  <= stateNext;
            ram_we    <= ramWeNext;
            ram_oe    <= ramOeNext;
            ram_addr  <= ramAddrNext;
            ram_din   <= ramDinNext;
            rsp_valid <= rspValidNext;
            rsp_data  <= rspDataNext;
`ifdef SEQ_RR_ARB_EN
            lastWrReg <= lastWrNext;
`endif
        end
    end

endmodule
